// File: rtl/cache_refill_fsm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cache_refill_fsm_if
// Description : Bundles the lookup-stage, memory and refill-array signals of
//               the data-cache miss handler into one interface.
//               master = the refill FSM, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_refill_fsm_if #(
    parameter int WAY      = 2,
    parameter int INDEXLEN = 8,
    parameter int TAGLEN   = 20
);
    localparam int WAYW = (WAY > 1) ? $clog2(WAY) : 1;

    // Lookup stage -> miss handler
    logic                miss_valid;
    logic                miss_ready;
    logic [TAGLEN-1:0]   miss_tag;
    logic [INDEXLEN-1:0] miss_idx;
    logic [WAYW-1:0]     victim_way;
    logic                victim_dirty;
    logic [TAGLEN-1:0]   victim_tag;
    logic [127:0]        victim_data;

    // Memory writeback port
    logic                wr_req;
    logic [31:0]         wr_addr;
    logic [127:0]        wr_data;
    logic                wr_rdy;

    // Memory read port and return channel
    logic                rd_req;
    logic [31:0]         rd_addr;
    logic                rd_rdy;
    logic                ret_valid;
    logic                ret_last;
    logic [31:0]         ret_data;

    // Refill write into the tag/V and data arrays
    logic                refill_we;
    logic [WAYW-1:0]     refill_way;
    logic [INDEXLEN-1:0] refill_idx;
    logic [TAGLEN-1:0]   refill_tag;
    logic [127:0]        refill_data;

    // Status
    logic                done;
    logic                ret_err;

    modport master (
        input  miss_valid, miss_tag, miss_idx, victim_way, victim_dirty,
               victim_tag, victim_data, wr_rdy, rd_rdy, ret_valid, ret_last,
               ret_data,
        output miss_ready, wr_req, wr_addr, wr_data, rd_req, rd_addr,
               refill_we, refill_way, refill_idx, refill_tag, refill_data,
               done, ret_err
    );

    modport slave (
        output miss_valid, miss_tag, miss_idx, victim_way, victim_dirty,
               victim_tag, victim_data, wr_rdy, rd_rdy, ret_valid, ret_last,
               ret_data,
        input  miss_ready, wr_req, wr_addr, wr_data, rd_req, rd_addr,
               refill_we, refill_way, refill_idx, refill_tag, refill_data,
               done, ret_err
    );
endinterface
`default_nettype wire

// File: rtl/cache_refill_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cache_refill_fsm
// Description : Data-cache miss handler. Writes back a dirty victim, fetches
//               the missing line as a 4-beat burst and issues one refill
//               write into the selected way. Outputs depend only on state and
//               latched registers.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_fsm #(
    parameter int WAY       = 2,
    parameter int INDEXLEN  = 8,
    parameter int TAGLEN    = 20,
    parameter int OFFSETLEN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    cache_refill_fsm_if.master    bus
);
    localparam int WAYW = (WAY > 1) ? $clog2(WAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_RREQ  = 3'd2,
        S_RRECV = 3'd3,
        S_FILL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [TAGLEN-1:0]   r_tag;
    logic [INDEXLEN-1:0] r_idx;
    logic [WAYW-1:0]     r_way;
    logic [TAGLEN-1:0]   r_vtag;
    logic [127:0]        r_vdata;
    logic [127:0]        r_line;
    logic [1:0]          r_cnt;
    logic                r_full;    // all four words captured; later beats dropped
    logic                r_err;

    logic                w_accept;
    logic                w_beat;
    logic                w_last;

    assign w_accept = (r_state == S_IDLE) && bus.miss_valid;
    assign w_beat   = (r_state == S_RRECV) && bus.ret_valid;
    assign w_last   = w_beat && bus.ret_last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; handshake inputs only matter in their own state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.miss_valid) w_next = bus.victim_dirty ? S_WB : S_RREQ;
            S_WB:    if (bus.wr_rdy)     w_next = S_RREQ;
            S_RREQ:  if (bus.rd_rdy)     w_next = S_RRECV;
            S_RRECV: if (w_last)         w_next = S_FILL;
            S_FILL:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Miss latches, line assembly, beat counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag   <= '0;
            r_idx   <= '0;
            r_way   <= '0;
            r_vtag  <= '0;
            r_vdata <= '0;
            r_line  <= '0;
            r_cnt   <= 2'd0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag   <= bus.miss_tag;
                r_idx   <= bus.miss_idx;
                r_way   <= bus.victim_way;
                r_vtag  <= bus.victim_tag;
                r_vdata <= bus.victim_data;
                // Clearing here makes missing words read as zero after an early last
                r_line  <= '0;
                r_cnt   <= 2'd0;
                r_full  <= 1'b0;
            end
            if (r_state == S_RREQ) begin
                r_cnt  <= 2'd0;
                r_full <= 1'b0;
            end
            if (w_beat && !r_full) begin
                r_line[{r_cnt, 5'b00000} +: 32] <= bus.ret_data;
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_full <= 1'b1;
                end
            end
            // Last must coincide with the fourth stored word; anything else is an error
            if (w_last && ((r_cnt != 2'd3) || r_full)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.miss_ready  = (r_state == S_IDLE);
    assign bus.wr_req      = (r_state == S_WB);
    assign bus.wr_addr     = {r_vtag, r_idx, {OFFSETLEN{1'b0}}};
    assign bus.wr_data     = r_vdata;
    assign bus.rd_req      = (r_state == S_RREQ);
    assign bus.rd_addr     = {r_tag, r_idx, {OFFSETLEN{1'b0}}};
    assign bus.refill_we   = (r_state == S_FILL);
    assign bus.refill_way  = r_way;
    assign bus.refill_idx  = r_idx;
    assign bus.refill_tag  = r_tag;
    assign bus.refill_data = r_line;
    assign bus.done        = (r_state == S_DONE);
    assign bus.ret_err     = r_err;

endmodule
`default_nettype wire

// File: doc/cache_refill_fsm.md
# cache_refill_fsm

Miss-handling stage of the data cache. Sits directly downstream of the lookup stage that contains the tag/V and data array wrappers. On a reported miss it writes back the dirty victim line over the memory write port, fetches the missing line as a 4-beat read burst, and then issues one refill write into the tag/V and data arrays of the selected way. The lookup stage stalls while this block is busy.

## Interface
Parameters:
- WAY, 2, associativity; the victim way index is $clog2(WAY) bits
- INDEXLEN, 8, set index width
- TAGLEN, 20, tag width
- OFFSETLEN, 4, byte offset width; line = 16 bytes = 4 × 32-bit words
- TAGLEN+INDEXLEN+OFFSETLEN must equal 32

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- miss_valid  in  1  lookup stage reports a miss
- miss_ready  out  1  block can accept a miss; high only in IDLE
- miss_tag  in  TAGLEN  tag of the missing address
- miss_idx  in  INDEXLEN  set index of the missing address
- victim_way  in  $clog2(WAY)  way to replace, from the FIFO way generator
- victim_dirty  in  1  victim line is valid and dirty
- victim_tag  in  TAGLEN  tag of the victim line
- victim_data  in  128  full victim line
- wr_req  out  1  writeback request
- wr_addr  out  32  writeback address {victim_tag, miss_idx, 0}
- wr_data  out  128  writeback line
- wr_rdy  in  1  memory accepts the writeback
- rd_req  out  1  line read request
- rd_addr  out  32  read address {miss_tag, miss_idx, 0}
- rd_rdy  in  1  memory accepts the read request
- ret_valid  in  1  return beat valid
- ret_last  in  1  final return beat
- ret_data  in  32  return beat data
- refill_we  out  1  one-cycle write strobe to the tag/V and data arrays
- refill_way  out  $clog2(WAY)  target way
- refill_idx  out  INDEXLEN  target set
- refill_tag  out  TAGLEN  tag written; V is written as 1
- refill_data  out  128  assembled line
- done  out  1  one-cycle pulse: miss resolved, lookup may replay
- ret_err  out  1  sticky: ret_last arrived on the wrong beat; cleared only by reset

## Operation
- States: IDLE, WB, RREQ, RRECV, FILL, DONE.
- IDLE: miss_ready=1. When miss_valid=1, the miss is accepted.
  - On acceptance, latch miss_tag, miss_idx, victim_way, victim_dirty, victim_tag and victim_data.
  - Next state is WB if victim_dirty=1, otherwise RREQ.
- WB: wr_req=1, with wr_addr and wr_data driven from the latched values and held stable. Move to RREQ in the cycle after wr_rdy is sampled high.
- RREQ: rd_req=1 with rd_addr held stable. Move to RRECV in the cycle after rd_rdy is sampled high. The 2-bit beat counter is cleared.
- RRECV: each cycle with ret_valid=1 stores ret_data into word[cnt] (bits 32·cnt+31:32·cnt) and increments cnt.
  - When ret_last=1, move to FILL.
  - If ret_last=1 arrives with cnt≠3, set ret_err. Words not yet received are filled with 0.
  - If cnt=3 is captured without ret_last, further beats are not stored. The block stays in RRECV until ret_last arrives.
- FILL: refill_we=1 for exactly one cycle, with refill_way, refill_idx, refill_tag and refill_data driven from the latched and assembled values. Next state is DONE.
- DONE: done=1 for one cycle, then IDLE.
- ret_valid, wr_rdy and rd_rdy are ignored in every state other than the one that consumes them.
- The line buffer is cleared on each acceptance, so no stale data leaks between misses.

## Timing
- Reset values: state IDLE, miss_ready=1 (combinational from IDLE), all other outputs 0, cnt=0, ret_err=0.
- Reset mid-operation: the block returns to IDLE the next cycle and drops wr_req/rd_req without completing. Return beats still in flight afterwards are ignored.
- All outputs are registered or decoded purely from state and latched registers. There is no combinational path from any input to any output except miss_ready, which depends on state only.
- Clean miss, all ready inputs high, beats back-to-back:
  - accept at cycle 0
  - RREQ at cycle 1
  - beats at cycles 2–5
  - FILL at cycle 6
  - done at cycle 7
  - miss_ready at cycle 8
- A dirty miss adds 1 cycle plus the wr_rdy wait.
- miss_valid held high through DONE is not re-accepted until the block is back in IDLE.

## Test plan
- Clean miss: tag=0x12345, idx=0x0A, way=1, dirty=0, rd_rdy=1, beats 0x11111111..0x44444444.
  - rd_addr=0x123450A0.
  - refill_data=0x44444444_33333333_22222222_11111111 with refill_we at cycle 6.
  - done at cycle 7.
  - wr_req never asserted.
- Dirty miss: victim_tag=0xABCDE, idx=0x03, wr_rdy low for 3 cycles.
  - wr_req is held 4 cycles with wr_addr=0xABCDE030 stable.
  - rd_req rises the cycle after the wr_rdy handshake.
- Gapped return: ret_valid low for 2 cycles between each beat → the line is assembled correctly and done is delayed by exactly 6 cycles.
- Early ret_last on beat 1 → ret_err=1, refill_data words 2–3 are 0, and FILL and done still occur.
- Reset asserted during RRECV after 2 beats → the next cycle is IDLE with all outputs 0. Subsequent stray ret_valid beats leave refill_we=0, and a new miss then completes normally.
- Back-to-back misses with miss_valid held high → the second miss is accepted only in the cycle after done, with fresh latched values.
